sata_dma_stream_limiter: RTL and testbench

- Sits directly downstream of the DMA stream multiplexer; consumes the selected stream and gates it to exactly the number of words programmed by a per-transfer length command.
- Marks the last word of each transfer with an end-of-packet flag, signals completion and supports abort.
- Keeps the DMA engine from over- or under-reading the FIS data path when the selected source produces more data than the current command needs.

---
 rtl/sata_dma_stream_limiter.sv | 135 +++++++++++++
 tb/tb_sata_dma_stream_limiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/sata_dma_stream_limiter.sv
// sata_dma_stream_limiter
//
// Sits downstream of the DMA stream multiplexer. It lets through exactly the
// number of words given by a per-transfer length command and flags the last
// word with o_eop. Outside a transfer i_rdy stays low, so any excess words
// from the selected source wait at the mux. Data is not registered: in XFER
// the stream passes straight through with zero latency.
//
// Ports:
//   clk      - system clock
//   reset_n  - asynchronous active-low reset
//   cmd_len  - transfer length in words (0 = empty transfer)
//   cmd_val  - command valid
//   cmd_rdy  - command ready (high in IDLE)
//   abort    - synchronous abort, level, sampled on clk
//   i_dat    - input stream data
//   i_val    - input stream valid
//   i_rdy    - input stream ready
//   o_dat    - output stream data (follows i_dat)
//   o_val    - output stream valid
//   o_rdy    - output stream ready
//   o_eop    - last word of the transfer, qualified by o_val
//   busy     - transfer in progress
//   done     - one-cycle pulse after the last word's handshake
//   aborted  - one-cycle pulse after an abort in XFER
module sata_dma_stream_limiter #(
  parameter int WIDTH    = 32,
  parameter int LENGTH_W = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [LENGTH_W-1:0] cmd_len,
  input  logic                cmd_val,
  output logic                cmd_rdy,
  input  logic                abort,
  input  logic [WIDTH-1:0]    i_dat,
  input  logic                i_val,
  output logic                i_rdy,
  output logic [WIDTH-1:0]    o_dat,
  output logic                o_val,
  input  logic                o_rdy,
  output logic                o_eop,
  output logic                busy,
  output logic                done,
  output logic                aborted
);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;

  localparam logic [LENGTH_W-1:0] ONE = LENGTH_W'(1);

  state_e              state_q, state_d;
  logic [LENGTH_W-1:0] count_q, count_d;
  logic                done_q, done_d;
  logic                aborted_q, aborted_d;
  logic                wordMoved;

  // A word moves only when both sides agree; i_rdy mirrors o_rdy in XFER so
  // this is the same event seen from either side.
  assign wordMoved = (state_q == XFER) && i_val && o_rdy;

  // Next-state and output logic. Abort takes priority over completion so a
  // last word accepted together with abort produces aborted, never done.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    cmd_rdy   = 1'b0;
    i_rdy     = 1'b0;
    o_val     = 1'b0;
    o_eop     = 1'b0;

    unique case (state_q)
      IDLE: begin
        cmd_rdy = 1'b1;
        if (cmd_val) begin
          if (cmd_len != '0) begin
            count_d = cmd_len;
            state_d = XFER;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      XFER: begin
        i_rdy = o_rdy;
        o_val = i_val;
        o_eop = (count_q == ONE);
        if (abort) begin
          state_d   = IDLE;
          count_d   = '0;
          aborted_d = 1'b1;
        end else if (wordMoved && (count_q != '0)) begin
          count_d = count_q - ONE;
          if (count_q == ONE) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  // State, counter and the registered completion pulses. Reset drops
  // straight to IDLE with no pulse of either kind.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign o_dat   = i_dat;
  assign busy    = (state_q == XFER);
  assign done    = done_q;
  assign aborted = aborted_q;

endmodule

// File: tb/tb_sata_dma_stream_limiter.sv
// Testbench for sata_dma_stream_limiter: a per-cycle vector table covering
// normal transfers, stalls, empty and single-word transfers, back-to-back
// commands and abort, followed by hand-written sequences for abort on the
// last word and reset asserted mid-transfer.
module tb_sata_dma_stream_limiter;

  localparam int WIDTH    = 32;
  localparam int LENGTH_W = 16;

  logic                clk;
  logic                reset_n;
  logic [LENGTH_W-1:0] cmd_len;
  logic                cmd_val;
  logic                cmd_rdy;
  logic                abort;
  logic [WIDTH-1:0]    i_dat;
  logic                i_val;
  logic                i_rdy;
  logic [WIDTH-1:0]    o_dat;
  logic                o_val;
  logic                o_rdy;
  logic                o_eop;
  logic                busy;
  logic                done;
  logic                aborted;

  // Expected output bits, packed as {cmd_rdy, i_rdy, o_val, o_eop, busy, done, aborted}
  typedef struct {
    logic                cmdVal;
    logic [LENGTH_W-1:0] cmdLen;
    logic                abortIn;
    logic                iVal;
    logic [WIDTH-1:0]    iDat;
    logic                oRdy;
    logic [6:0]          expOut;
  } vec_t;

  vec_t vecs[$];
  int   compared   = 0;
  int   mismatched = 0;

  sata_dma_stream_limiter #(
    .WIDTH    (WIDTH),
    .LENGTH_W (LENGTH_W)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .cmd_len (cmd_len),
    .cmd_val (cmd_val),
    .cmd_rdy (cmd_rdy),
    .abort   (abort),
    .i_dat   (i_dat),
    .i_val   (i_val),
    .i_rdy   (i_rdy),
    .o_dat   (o_dat),
    .o_val   (o_val),
    .o_rdy   (o_rdy),
    .o_eop   (o_eop),
    .busy    (busy),
    .done    (done),
    .aborted (aborted)
  );

  // 10 ns clock; inputs change on the falling edge, checks follow 1 ns later
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Append one cycle of stimulus and its expected outputs to the table
  task automatic addVec(input logic cv, input int cl, input logic ab, input logic iv,
                        input logic [WIDTH-1:0] d, input logic ordy, input logic [6:0] e);
    vec_t v;
    v.cmdVal  = cv;
    v.cmdLen  = LENGTH_W'(cl);
    v.abortIn = ab;
    v.iVal    = iv;
    v.iDat    = d;
    v.oRdy    = ordy;
    v.expOut  = e;
    vecs.push_back(v);
  endtask

  // Drive all inputs with blocking assignments
  task automatic applyStimulus(input logic cv, input int cl, input logic ab, input logic iv,
                               input logic [WIDTH-1:0] d, input logic ordy);
    cmd_val = cv;
    cmd_len = LENGTH_W'(cl);
    abort   = ab;
    i_val   = iv;
    i_dat   = d;
    o_rdy   = ordy;
  endtask

  // Compare the control outputs and, when a word is offered, the data
  task automatic checkOutput(input string name, input logic [6:0] e, input logic [WIDTH-1:0] expDat);
    logic [6:0] act;
    act = {cmd_rdy, i_rdy, o_val, o_eop, busy, done, aborted};
    compared++;
    if (act !== e) begin
      mismatched++;
      $display("[TB] FAIL %s: {cmd_rdy,i_rdy,o_val,o_eop,busy,done,aborted} got %b expected %b",
               name, act, e);
    end
    if (e[4]) begin
      compared++;
      if (o_dat !== expDat) begin
        mismatched++;
        $display("[TB] FAIL %s o_dat: got %h expected %h", name, o_dat, expDat);
      end
    end
  endtask

  // Advance to the next falling edge, drive, then check
  task automatic stepCheck(input string name, input logic cv, input int cl, input logic ab,
                           input logic iv, input logic [WIDTH-1:0] d, input logic ordy,
                           input logic [6:0] e);
    @(negedge clk);
    applyStimulus(cv, cl, ab, iv, d, ordy);
    #1;
    checkOutput(name, e, d);
  endtask

  localparam logic [6:0] IDL  = 7'b1000000;
  localparam logic [6:0] IDN  = 7'b1000010;
  localparam logic [6:0] IDA  = 7'b1000001;
  localparam logic [6:0] XF   = 7'b0110100;
  localparam logic [6:0] XFE  = 7'b0111100;
  localparam logic [6:0] XST  = 7'b0010100;
  localparam logic [6:0] XSTE = 7'b0011100;
  localparam logic [6:0] XNV  = 7'b0100100;

  initial begin
    reset_n = 1'b0;
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);

    // Length 4, free-flowing
    addVec(1, 4, 0, 1, 32'hA0, 1, IDL);
    addVec(0, 0, 0, 1, 32'hA0, 1, XF);
    addVec(0, 0, 0, 1, 32'hA1, 1, XF);
    addVec(0, 0, 0, 1, 32'hA2, 1, XF);
    addVec(0, 0, 0, 1, 32'hA3, 1, XFE);
    addVec(0, 0, 0, 1, 32'hA4, 1, IDN);
    addVec(0, 0, 0, 1, 32'hA4, 1, IDL);
    // Length 3 with o_rdy 1,0,0,1,0,1
    addVec(1, 3, 0, 1, 32'hB0, 0, IDL);
    addVec(0, 0, 0, 1, 32'hB0, 1, XF);
    addVec(0, 0, 0, 1, 32'hB1, 0, XST);
    addVec(0, 0, 0, 1, 32'hB1, 0, XST);
    addVec(0, 0, 0, 1, 32'hB1, 1, XF);
    addVec(0, 0, 0, 1, 32'hB2, 0, XSTE);
    addVec(0, 0, 0, 1, 32'hB2, 1, XFE);
    addVec(0, 0, 0, 1, 32'hB3, 1, IDN);
    // Empty transfer
    addVec(1, 0, 0, 0, 32'h0, 0, IDL);
    addVec(0, 0, 0, 0, 32'h0, 0, IDN);
    addVec(0, 0, 0, 0, 32'h0, 0, IDL);
    // Length 1, then length 2 accepted on the done cycle
    addVec(1, 1, 0, 1, 32'hC0, 1, IDL);
    addVec(0, 0, 0, 1, 32'hC0, 1, XFE);
    addVec(1, 2, 0, 1, 32'hC1, 1, IDN);
    addVec(0, 0, 0, 1, 32'hC1, 1, XF);
    addVec(0, 0, 0, 1, 32'hC2, 1, XFE);
    addVec(0, 0, 0, 1, 32'hC3, 1, IDN);
    // Length 10, abort after 5 handshakes (one bubble with i_val low)
    addVec(1, 10, 0, 1, 32'hD0, 1, IDL);
    addVec(0, 0, 0, 1, 32'hD0, 1, XF);
    addVec(0, 0, 0, 1, 32'hD1, 1, XF);
    addVec(0, 0, 0, 0, 32'hD2, 1, XNV);
    addVec(0, 0, 0, 1, 32'hD2, 1, XF);
    addVec(0, 0, 0, 1, 32'hD3, 1, XF);
    addVec(0, 0, 0, 1, 32'hD4, 1, XF);
    addVec(0, 0, 1, 1, 32'hD5, 1, XF);
    addVec(0, 0, 0, 1, 32'hD6, 1, IDA);
    // Length 2 after abort restarts the counter
    addVec(1, 2, 0, 1, 32'hE0, 1, IDL);
    addVec(0, 0, 0, 1, 32'hE0, 1, XF);
    addVec(0, 0, 0, 1, 32'hE1, 1, XFE);
    addVec(0, 0, 0, 1, 32'hE2, 1, IDN);
    // Abort in IDLE is ignored, also together with a command
    addVec(0, 0, 1, 0, 32'h0, 0, IDL);
    addVec(1, 1, 1, 1, 32'hF0, 1, IDL);
    addVec(0, 0, 0, 1, 32'hF0, 1, XFE);
    addVec(0, 0, 0, 0, 32'h0, 0, IDN);
    addVec(0, 0, 0, 0, 32'h0, 0, IDL);

    // Reset state
    #12;
    checkOutput("reset", IDL, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 32'h55, 1'b1);
    #1;
    checkOutput("after reset release", IDL, 32'h0);

    foreach (vecs[i]) begin
      @(negedge clk);
      applyStimulus(vecs[i].cmdVal, int'(vecs[i].cmdLen), vecs[i].abortIn,
                    vecs[i].iVal, vecs[i].iDat, vecs[i].oRdy);
      #1;
      checkOutput($sformatf("vec%0d", i), vecs[i].expOut, vecs[i].iDat);
    end

    // Abort on the last word: aborted wins, no done
    stepCheck("abortLast cmd",   1, 1, 0, 1, 32'h11, 1, IDL);
    stepCheck("abortLast word",  0, 0, 1, 1, 32'h11, 1, XFE);
    stepCheck("abortLast pulse", 0, 0, 0, 1, 32'h12, 1, IDA);
    stepCheck("abortLast quiet", 0, 0, 0, 1, 32'h12, 1, IDL);

    // Reset mid-transfer with 7 words left
    stepCheck("rstMid cmd",  1, 9, 0, 1, 32'h20, 1, IDL);
    stepCheck("rstMid w0",   0, 0, 0, 1, 32'h20, 1, XF);
    stepCheck("rstMid w1",   0, 0, 0, 1, 32'h21, 1, XF);
    stepCheck("rstMid cnt7", 0, 0, 0, 1, 32'h22, 0, XST);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("rstMid asserted", IDL, 32'h22);
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 32'h23, 1'b1);
    #1;
    checkOutput("rstMid released", IDL, 32'h23);
    stepCheck("rstMid no pulse", 0, 0, 0, 1, 32'h23, 1, IDL);
    stepCheck("rstMid new cmd",  1, 2, 0, 1, 32'h30, 1, IDL);
    stepCheck("rstMid new w0",   0, 0, 0, 1, 32'h30, 1, XF);
    stepCheck("rstMid new w1",   0, 0, 0, 1, 32'h31, 1, XFE);
    stepCheck("rstMid new done", 0, 0, 0, 1, 32'h32, 1, IDN);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
